core_mem_arbiter: RTL and testbench

Shares one single-beat AXI4 master port between the core's instruction-fetch requester and its data (mem stage) requester. It sits between the pipeline stages and the external memory AXI slave. It serialises accesses, grants data priority with a starvation guard for fetch, and returns read data and completion acks to each requester.

---
 rtl/core_mem_pkg.sv | 24 ++
 rtl/core_mem_arb_prio.sv | 40 ++++
 rtl/core_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core memory arbiter: FSM states,
// AXI response codes and requester owner encodings.
package core_mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        ACK     = 3'd5
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/core_mem_arb_prio.sv
// Fetch/data grant selection: data wins unless it has already taken
// C_MAX_DATA_STREAK consecutive grants while fetch was waiting.
module core_mem_arb_prio
    import core_mem_pkg::*;
#(
    parameter int C_MAX_DATA_STREAK = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_i_req,
    input  logic i_d_req,
    input  logic i_grant_en,
    output logic o_grant,
    output logic o_owner
);

    logic [STREAK_W-1:0] r_streak;
    logic                w_streak_full;

    assign w_streak_full = (r_streak == STREAK_W'(C_MAX_DATA_STREAK));

    always_comb begin
        o_grant = i_grant_en && (i_i_req || i_d_req);
        o_owner = (i_d_req && !(i_i_req && w_streak_full)) ? OWN_D : OWN_I;
    end

    // Streak only grows while fetch is actually being held off.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_streak <= '0;
        end else if (o_grant) begin
            if (o_owner == OWN_D && i_i_req) begin
                r_streak <= r_streak + STREAK_W'(1);
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Serialises single-beat AXI4 accesses from the fetch and data requesters
// onto one master port; all outputs are registered.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH  = 32,
    parameter int C_OFFSET_WIDTH    = 28,
    parameter int C_MAX_DATA_STREAK = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        I_REQ,
    input  logic [31:0]                 I_ADDR,
    output logic [C_AXI_DATA_WIDTH-1:0] I_RDATA,
    output logic                        I_ACK,
    input  logic                        D_REQ,
    input  logic                        D_WE,
    input  logic [31:0]                 D_ADDR,
    input  logic [C_AXI_DATA_WIDTH-1:0] D_WDATA,
    input  logic [3:0]                  D_STRB,
    output logic [C_AXI_DATA_WIDTH-1:0] D_RDATA,
    output logic                        D_ACK,
    output logic [C_OFFSET_WIDTH-1:0]   M_ARADDR,
    output logic                        M_ARVALID,
    input  logic                        M_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]                  M_RRESP,
    input  logic                        M_RVALID,
    output logic                        M_RREADY,
    output logic [C_OFFSET_WIDTH-1:0]   M_AWADDR,
    output logic                        M_AWVALID,
    input  logic                        M_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0]                  M_WSTRB,
    output logic                        M_WVALID,
    input  logic                        M_WREADY,
    input  logic [1:0]                  M_BRESP,
    input  logic                        M_BVALID,
    output logic                        M_BREADY,
    output logic                        ERR,
    output state_t                      DBG_STATE
);

    state_t                      r_state;
    logic                        r_owner;
    logic [C_OFFSET_WIDTH-1:0]   r_addr;
    logic [C_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [3:0]                  r_strb;
    logic                        r_arvalid;
    logic                        r_rready;
    logic                        r_awvalid;
    logic                        r_wvalid;
    logic                        r_bready;
    logic [C_AXI_DATA_WIDTH-1:0] r_i_rdata;
    logic [C_AXI_DATA_WIDTH-1:0] r_d_rdata;
    logic                        r_i_ack;
    logic                        r_d_ack;
    logic                        r_err;

    logic                        w_grant;
    logic                        w_owner;
    logic                        w_aw_done;
    logic                        w_w_done;
    logic [63-2*C_OFFSET_WIDTH:0] w_unused_addr;

    assign w_unused_addr = {I_ADDR[31:C_OFFSET_WIDTH], D_ADDR[31:C_OFFSET_WIDTH]};

    core_mem_arb_prio #(
        .C_MAX_DATA_STREAK(C_MAX_DATA_STREAK)
    ) u_prio (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_i_req   (I_REQ),
        .i_d_req   (D_REQ),
        .i_grant_en(r_state == IDLE),
        .o_grant   (w_grant),
        .o_owner   (w_owner)
    );

    // A write channel counts as done once its VALID has already dropped or
    // its handshake lands this cycle; AW and W may finish in either order.
    assign w_aw_done = !r_awvalid || M_AWREADY;
    assign w_w_done  = !r_wvalid  || M_WREADY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_owner   <= OWN_I;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_owner;
                        if (w_owner == OWN_D) begin
                            r_addr  <= D_ADDR[C_OFFSET_WIDTH-1:0];
                            r_wdata <= D_WDATA;
                            r_strb  <= D_STRB;
                        end else begin
                            r_addr  <= I_ADDR[C_OFFSET_WIDTH-1:0];
                        end
                        if (w_owner == OWN_D && D_WE) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (M_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_RVALID) begin
                        r_rready <= 1'b0;
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= M_RDATA;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_i_rdata <= M_RDATA;
                            r_i_ack   <= 1'b1;
                        end
                        if (M_RRESP != OKAY) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ACK;
                    end
                end
                WR_REQ: begin
                    if (M_AWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (M_WREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_BVALID) begin
                        r_bready <= 1'b0;
                        r_d_ack  <= (r_owner == OWN_D);
                        r_i_ack  <= (r_owner == OWN_I);
                        if (M_BRESP != OKAY) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign I_RDATA   = r_i_rdata;
    assign I_ACK     = r_i_ack;
    assign D_RDATA   = r_d_rdata;
    assign D_ACK     = r_d_ack;
    assign M_ARADDR  = r_addr;
    assign M_ARVALID = r_arvalid;
    assign M_RREADY  = r_rready;
    assign M_AWADDR  = r_addr;
    assign M_AWVALID = r_awvalid;
    assign M_WDATA   = r_wdata;
    assign M_WSTRB   = r_strb;
    assign M_WVALID  = r_wvalid;
    assign M_BREADY  = r_bready;
    assign ERR       = r_err;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: requester driver tasks, a behavioural
// AXI slave with programmable ready/valid delays, and per-scenario checks.
module tb_core_mem_arbiter;
    import core_mem_pkg::*;

    logic        CLK;
    logic        RST;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic [31:0] I_RDATA;
    logic        I_ACK;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [3:0]  D_STRB;
    logic [31:0] D_RDATA;
    logic        D_ACK;
    logic [27:0] M_ARADDR;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RVALID;
    logic        M_RREADY;
    logic [27:0] M_AWADDR;
    logic        M_AWVALID;
    logic        M_AWREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WVALID;
    logic        M_WREADY;
    logic [1:0]  M_BRESP;
    logic        M_BVALID;
    logic        M_BREADY;
    logic        ERR;
    state_t      DBG_STATE;

    int checks   = 0;
    int failures = 0;

    core_mem_arbiter #(
        .C_AXI_DATA_WIDTH (32),
        .C_OFFSET_WIDTH   (28),
        .C_MAX_DATA_STREAK(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_STRB(D_STRB), .D_RDATA(D_RDATA), .D_ACK(D_ACK),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .ERR(ERR), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- behavioural AXI slave ----------------
    logic [31:0] mem [0:255];
    int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
    logic [1:0]  rresp_val = OKAY;
    logic [1:0]  bresp_val = OKAY;
    int          ar_wait, aw_wait, w_wait, r_wait, cyc;
    int          r_hs = 0, w_hs = 0, aw_hs = 0, b_hs = 0;
    int          aw_hs_cyc, w_hs_cyc;
    logic        p_arv, p_rrdy, p_awv, p_wv, p_brdy;
    logic        rd_pend, aw_got, w_got;
    logic [7:0]  rd_idx, wr_idx;
    logic [31:0] wd_l;
    logic [3:0]  ws_l;
    logic [27:0] last_araddr, last_awaddr;

    initial begin
        M_ARREADY = 0; M_RVALID = 0; M_RDATA = '0; M_RRESP = OKAY;
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = OKAY;
        p_arv = 0; p_rrdy = 0; p_awv = 0; p_wv = 0; p_brdy = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; rd_idx = '0; wr_idx = '0;
        wd_l = '0; ws_l = '0; last_araddr = '0; last_awaddr = '0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; cyc = 0;
        aw_hs_cyc = 0; w_hs_cyc = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST) begin
                M_ARREADY = 0; M_RVALID = 0; M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0;
                p_arv = 0; p_rrdy = 0; p_awv = 0; p_wv = 0; p_brdy = 0;
                rd_pend = 0; aw_got = 0; w_got = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0;
                continue;
            end
            // retire handshakes that completed on the previous rising edge
            if (M_ARREADY && p_arv) begin
                rd_pend = 1; rd_idx = M_ARADDR[9:2]; last_araddr = M_ARADDR;
                r_wait = 0; ar_wait = 0;
            end
            if (M_RVALID && p_rrdy) begin
                M_RVALID = 0; rd_pend = 0; r_hs++;
            end
            if (M_AWREADY && p_awv) begin
                aw_got = 1; wr_idx = M_AWADDR[9:2]; last_awaddr = M_AWADDR;
                aw_hs++; aw_hs_cyc = cyc; aw_wait = 0;
            end
            if (M_WREADY && p_wv) begin
                w_got = 1; wd_l = M_WDATA; ws_l = M_WSTRB;
                w_hs++; w_hs_cyc = cyc; w_wait = 0;
            end
            if (M_BVALID && p_brdy) begin
                M_BVALID = 0; b_hs++;
            end
            if (aw_got && w_got) begin
                for (int b = 0; b < 4; b++)
                    if (ws_l[b]) mem[wr_idx][8*b +: 8] = wd_l[8*b +: 8];
                aw_got = 0; w_got = 0;
                M_BVALID = 1; M_BRESP = bresp_val;
            end
            if (rd_pend && !M_RVALID) begin
                if (r_wait >= r_delay) begin
                    M_RVALID = 1; M_RDATA = mem[rd_idx]; M_RRESP = rresp_val;
                end else begin
                    r_wait++;
                end
            end
            M_ARREADY = 0;
            if (M_ARVALID) begin
                if (ar_wait >= ar_delay) M_ARREADY = 1; else ar_wait++;
            end
            M_AWREADY = 0;
            if (M_AWVALID) begin
                if (aw_wait >= aw_delay) M_AWREADY = 1; else aw_wait++;
            end
            M_WREADY = 0;
            if (M_WVALID) begin
                if (w_wait >= w_delay) M_WREADY = 1; else w_wait++;
            end
            p_arv = M_ARVALID; p_rrdy = M_RREADY; p_awv = M_AWVALID;
            p_wv = M_WVALID; p_brdy = M_BREADY;
        end
    end

    // ---------------- ack pulse counters ----------------
    int i_ack_cnt = 0, d_ack_cnt = 0;
    initial begin
        forever begin
            @(negedge CLK);
            if (I_ACK) i_ack_cnt++;
            if (D_ACK) d_ack_cnt++;
        end
    end

    // ---------------- requester drivers ----------------
    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] data, output int lat);
        @(negedge CLK);
        I_ADDR = addr; I_REQ = 1'b1; lat = -1; data = '0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge CLK);
            if (I_ACK) begin lat = n; data = I_RDATA; break; end
        end
        I_REQ = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] data, output int lat);
        @(negedge CLK);
        D_WE = we; D_ADDR = addr; D_WDATA = wdata; D_STRB = strb; D_REQ = 1'b1;
        lat = -1; data = '0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge CLK);
            if (D_ACK) begin lat = n; data = D_RDATA; break; end
        end
        D_REQ = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY} !== 5'b0) begin
            failures++; $display("FAIL reset_handshake: got %b want 00000",
                {M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY});
        end
        checks++;
        if ({I_ACK, D_ACK, ERR} !== 3'b0) begin
            failures++; $display("FAIL reset_ack_err: got %b want 000", {I_ACK, D_ACK, ERR});
        end
        checks++;
        if ({I_RDATA, D_RDATA, M_WDATA} !== 96'h0) begin
            failures++; $display("FAIL reset_data: got %h %h %h want zeros", I_RDATA, D_RDATA, M_WDATA);
        end
        checks++;
        if ({M_ARADDR, M_AWADDR, M_WSTRB} !== 60'h0) begin
            failures++; $display("FAIL reset_addr: got %h %h %h want zeros", M_ARADDR, M_AWADDR, M_WSTRB);
        end
        checks++;
        if (DBG_STATE !== IDLE) begin
            failures++; $display("FAIL reset_state: got %0d want %0d", DBG_STATE, IDLE);
        end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_fetch_read();
        logic [31:0] d;
        int          lat;
        do_fetch(32'h0000_0004, d, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL fetch_lat: got %0d want 3", lat); end
        checks++;
        if (d !== 32'h7D00_8113) begin failures++; $display("FAIL fetch_rdata: got %h want 7d008113", d); end
        checks++;
        if (last_araddr !== 28'h000_0004) begin
            failures++; $display("FAIL fetch_araddr: got %h want 0000004", last_araddr);
        end
        @(negedge CLK);
        checks++;
        if (I_ACK !== 1'b0 || I_RDATA !== 32'h7D00_8113) begin
            failures++; $display("FAIL fetch_ack_pulse: ack %b rdata %h want 0 7d008113", I_ACK, I_RDATA);
        end
        do_fetch(32'hF000_0008, d, lat);
        checks++;
        if (last_araddr !== 28'h000_0008 || d !== 32'h2222_0002) begin
            failures++; $display("FAIL fetch_high_bits: addr %h data %h want 0000008 22220002", last_araddr, d);
        end
    endtask

    task automatic test_write_delayed_aw();
        logic [31:0] d;
        int          lat, b0, d0, w0, aw0;
        aw_delay = 2; w_delay = 0;
        b0 = b_hs; d0 = d_ack_cnt; w0 = w_hs; aw0 = aw_hs;
        do_data(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, d, lat);
        repeat (3) @(negedge CLK);
        aw_delay = 0;
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL wr_lat: got %0d want 5", lat); end
        checks++;
        if (!(w_hs_cyc < aw_hs_cyc)) begin
            failures++; $display("FAIL wr_order: w at %0d aw at %0d want w first", w_hs_cyc, aw_hs_cyc);
        end
        checks++;
        if (w_hs - w0 !== 1 || aw_hs - aw0 !== 1) begin
            failures++; $display("FAIL wr_hs_count: w %0d aw %0d want 1 1", w_hs - w0, aw_hs - aw0);
        end
        checks++;
        if (b_hs - b0 !== 1) begin failures++; $display("FAIL wr_b_count: got %0d want 1", b_hs - b0); end
        checks++;
        if (d_ack_cnt - d0 !== 1) begin failures++; $display("FAIL wr_ack_count: got %0d want 1", d_ack_cnt - d0); end
        checks++;
        if (mem[64] !== 32'hAAAA_5678) begin failures++; $display("FAIL wr_mem: got %h want aaaa5678", mem[64]); end
        checks++;
        if (last_awaddr !== 28'h000_0100 || ws_l !== 4'b0011) begin
            failures++; $display("FAIL wr_addr_strb: got %h %b want 0000100 0011", last_awaddr, ws_l);
        end
    endtask

    task automatic test_zero_wait_write();
        logic [31:0] d;
        int          lat;
        do_data(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, d, lat);
        repeat (2) @(negedge CLK);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL wr0_lat: got %0d want 3", lat); end
        checks++;
        if (mem[65] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr0_mem: got %h want deadbeef", mem[65]); end
    endtask

    task automatic test_arbitration();
        logic exp_i [10];
        logic seq_i [10];
        int   ack_c [10];
        int   n;
        exp_i = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        @(negedge CLK);
        I_ADDR = 32'h4; D_ADDR = 32'h8; D_WE = 1'b0; I_REQ = 1'b1; D_REQ = 1'b1;
        n = 0;
        for (int c = 1; c <= 80 && n < 10; c++) begin
            @(negedge CLK);
            if (I_ACK || D_ACK) begin seq_i[n] = I_ACK; ack_c[n] = c; n++; end
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
        checks++;
        if (n !== 10) begin failures++; $display("FAIL arb_count: got %0d want 10", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (seq_i[k] !== exp_i[k]) begin
                failures++; $display("FAIL arb_seq[%0d]: got fetch=%b want fetch=%b", k, seq_i[k], exp_i[k]);
            end
        end
        for (int k = 1; k < n; k++) begin
            checks++;
            if (ack_c[k] - ack_c[k-1] !== 4) begin
                failures++; $display("FAIL arb_spacing[%0d]: got %0d want 4", k, ack_c[k] - ack_c[k-1]);
            end
        end
        checks++;
        if (I_RDATA !== 32'h7D00_8113 || D_RDATA !== 32'h2222_0002) begin
            failures++; $display("FAIL arb_rdata: got %h %h want 7d008113 22220002", I_RDATA, D_RDATA);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        int          lat;
        checks++;
        if (ERR !== 1'b0) begin failures++; $display("FAIL err_before: got %b want 0", ERR); end
        rresp_val = SLVERR;
        do_data(1'b0, 32'h0000_0010, 32'h0, 4'b0000, d, lat);
        rresp_val = OKAY;
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL err_lat: got %0d want 3", lat); end
        checks++;
        if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL err_rdata: got %h want cafef00d", d); end
        checks++;
        if (ERR !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", ERR); end
        do_fetch(32'h0000_0004, d, lat);
        repeat (3) @(negedge CLK);
        checks++;
        if (ERR !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", ERR); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int          lat, i0;
        logic        found;
        @(negedge CLK);
        r_delay = 1; I_ADDR = 32'h4; I_REQ = 1'b1; i0 = i_ack_cnt; found = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (M_RREADY) begin found = 1'b1; break; end
        end
        checks++;
        if (found !== 1'b1) begin failures++; $display("FAIL rst_reach_rd_data: got %b want 1", found); end
        @(negedge CLK);
        #1;
        checks++;
        if (M_RVALID !== 1'b1 || M_RREADY !== 1'b1) begin
            failures++; $display("FAIL rst_pending: rvalid %b rready %b want 1 1", M_RVALID, M_RREADY);
        end
        RST = 1'b0; I_REQ = 1'b0;
        #1;
        checks++;
        if ({M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY, I_ACK, D_ACK, ERR} !== 8'b0) begin
            failures++; $display("FAIL rst_mid_ctrl: got %b want 00000000",
                {M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY, I_ACK, D_ACK, ERR});
        end
        checks++;
        if (I_RDATA !== 32'h0 || M_ARADDR !== 28'h0 || DBG_STATE !== IDLE) begin
            failures++; $display("FAIL rst_mid_regs: rdata %h araddr %h state %0d want 0 0 0",
                I_RDATA, M_ARADDR, DBG_STATE);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1; r_delay = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if (i_ack_cnt !== i0) begin failures++; $display("FAIL rst_no_ack: got %0d acks want 0", i_ack_cnt - i0); end
        do_fetch(32'h0000_0004, d, lat);
        checks++;
        if (lat !== 3 || d !== 32'h7D00_8113) begin
            failures++; $display("FAIL rst_fresh_fetch: lat %0d data %h want 3 7d008113", lat, d);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RST = 1'b0; I_REQ = 1'b0; I_ADDR = '0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0; D_STRB = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[1]  = 32'h7D00_8113;
        mem[2]  = 32'h2222_0002;
        mem[4]  = 32'hCAFE_F00D;
        mem[64] = 32'hAAAA_BBBB;

        test_reset();
        test_fetch_read();
        test_write_delayed_aw();
        test_zero_wait_write();
        test_arbitration();
        test_slverr();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
